xge_tx_arbiter: RTL and testbench
=================================

Name: xge_tx_arbiter

Overview:
- Two-source packet arbiter in front of the 10G MAC user TX interface, so one MAC TX port can be shared by two packet sources, e.g. packet_gen plus a control/loopback source.
- Grants whole packets round-robin, gated by the MAC's tx_ready.
- Re-registers the selected stream, enforces a programmable inter-packet gap and keeps per-source packet and protocol-error counters.
- Sits in the usclk domain between the sources and the MAC's tx_data/en/sop/eop/byte_vaild inputs.

Parameters:
- IPG_CYCLES, 1, idle usclk cycles inserted after each packet's eop before the next grant (0 = none).
- CNT_W, 32, width of each statistics counter.

Ports:
- usclk  in  1  clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- tx_ready  in  1  MAC can accept a new packet; sampled only when starting a packet.
- sN_data  in  64  source N data, N = 0,1 (bytes little-endian, byte 0 at [7:0]).
- sN_en  in  1  source N beat valid.
- sN_sop  in  1  source N first beat.
- sN_eop  in  1  source N last beat.
- sN_byte_vaild  in  3  valid bytes on eop beat; 0 = 8.
- sN_ready  out  1  beat accepted this cycle when sN_en & sN_ready.
- tx_data  out  64  to MAC.
- tx_data_en  out  1  to MAC.
- tx_data_sop  out  1  to MAC.
- tx_data_eop  out  1  to MAC.
- tx_data_byte_vaild  out  3  to MAC.
- sN_pkt_cnt  out  CNT_W  packets forwarded from source N.
- proto_err_cnt  out  CNT_W  protocol violations, both sources combined.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = 0 (source 1 wins the first tie), counters 0. Asynchronous; abandons any packet in flight. The MAC sees en drop with no eop; recovery is the MAC's responsibility.
- Source rule: a source presents its sop beat with sN_en=1 and holds all fields stable until sN_ready. reqN = sN_en & sN_sop.
- States: IDLE, PKT, GAP.
- IDLE:
  - sN_ready=0.
  - If tx_ready & (req0 | req1), register grant g and go to PKT.
  - If both request, g = ~rr; otherwise g = the requester.
  - On grant, rr <= g.
  - tx_ready is ignored while no request is present.
- PKT:
  - s{g}_ready=1; the other source's ready=0.
  - Each accepted beat is registered to tx_* on the next edge, giving a fixed 1-cycle latency.
  - tx_data_en = 1 only in cycles following an accepted beat. A source gap produces en=0 on the output; no data is invented.
  - tx_data_byte_vaild is forwarded only on eop beats, else 0.
  - First accepted beat without sop: discarded, nothing output, proto_err_cnt+1.
  - sop on a later beat within the same packet: beat forwarded with tx_data_sop forced 0, proto_err_cnt+1.
  - Accepted beat with eop (including single-beat sop&eop): s{g}_pkt_cnt+1. Go to GAP if IPG_CYCLES>0, else IDLE.
  - tx_ready is not sampled mid-packet.
- GAP:
  - Both readies 0; down-counter loaded with IPG_CYCLES-1 on entry.
  - Go to IDLE when the counter reaches 0.
  - Next earliest output sop: eop out-cycle + IPG_CYCLES + 2.
- Output registers clear en/sop/eop to 0 on any cycle without an accepted beat. tx_data keeps its last value.
- Counters wrap modulo 2^CNT_W.
- A proto error and a packet-count increment in the same cycle both apply.
- Requests arriving during PKT/GAP wait; requests are never lost while held.

Test Plan:
- Single source: s0 sends a 3-beat packet (bv=5), tx_ready=1, IPG_CYCLES=1.
  - tx_* shows the beats 1 cycle after acceptance: sop on beat 1, eop+bv=5 on beat 3.
  - s0_pkt_cnt=1, proto_err_cnt=0.
- Simultaneous requests: s0 and s1 both present sop from reset.
  - s1 is granted first (rr=0), then s0.
  - Output sops are separated by pkt_len + IPG_CYCLES + 1 cycles.
  - Both counts = 1.
- Fairness under saturation: both sources continuously send 2-beat packets for 20 packets.
  - Grants alternate 1,0,1,0…; s0_pkt_cnt = s1_pkt_cnt = 10.
- tx_ready=0 while s0 requests for 10 cycles.
  - s0_ready stays 0 and tx_data_en stays 0.
  - tx_ready rises: grant next edge, first output beat 2 edges after the rise.
- Protocol errors:
  - First beat without sop: beat dropped, proto_err_cnt=1.
  - Mid-packet sop: that beat is forwarded with tx_data_sop=0, proto_err_cnt=2.
  - The packet still completes with s0_pkt_cnt=1.
- sys_rst pulsed mid-packet (beat 2 of 4): outputs, counters and busy go to 0 immediately.
  - After release, a fresh s0 packet is forwarded normally.

Source files
------------

// File: rtl/xge_tx_arbiter_if.sv
// ==== xge_tx_arbiter_if : source/MAC stream bundle for the two-source TX arbiter (rev 1.0) ====
`default_nettype none

interface xge_tx_arbiter_if;
  logic        tx_ready;

  logic [63:0] s0_data;
  logic        s0_en;
  logic        s0_sop;
  logic        s0_eop;
  logic [2:0]  s0_byte_vaild;
  logic        s0_ready;

  logic [63:0] s1_data;
  logic        s1_en;
  logic        s1_sop;
  logic        s1_eop;
  logic [2:0]  s1_byte_vaild;
  logic        s1_ready;

  logic [63:0] tx_data;
  logic        tx_data_en;
  logic        tx_data_sop;
  logic        tx_data_eop;
  logic [2:0]  tx_data_byte_vaild;

  // arbiter side
  modport slave (
    input  tx_ready,
    input  s0_data, s0_en, s0_sop, s0_eop, s0_byte_vaild,
    input  s1_data, s1_en, s1_sop, s1_eop, s1_byte_vaild,
    output s0_ready, s1_ready,
    output tx_data, tx_data_en, tx_data_sop, tx_data_eop, tx_data_byte_vaild
  );

  // sources + MAC side
  modport master (
    output tx_ready,
    output s0_data, s0_en, s0_sop, s0_eop, s0_byte_vaild,
    output s1_data, s1_en, s1_sop, s1_eop, s1_byte_vaild,
    input  s0_ready, s1_ready,
    input  tx_data, tx_data_en, tx_data_sop, tx_data_eop, tx_data_byte_vaild
  );
endinterface

`default_nettype wire

// File: rtl/xge_tx_arbiter.sv
// ==== xge_tx_arbiter : round-robin whole-packet arbiter, two sources onto one 10G MAC TX port (rev 1.0) ====
`default_nettype none

module xge_tx_arbiter #(
  parameter int IPG_CYCLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic              usclk,
  input  logic              sys_rst,
  xge_tx_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]  s0_pkt_cnt,
  output logic [CNT_W-1:0]  s1_pkt_cnt,
  output logic [CNT_W-1:0]  proto_err_cnt,
  output logic              busy
);

  localparam int                 c_GAP_W    = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
  localparam logic               c_HAS_GAP  = (IPG_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_grant;
  logic               r_rr;
  logic               r_first;
  logic [c_GAP_W-1:0] r_gap_cnt;

  logic [63:0]        r_tx_data;
  logic               r_tx_en;
  logic               r_tx_sop;
  logic               r_tx_eop;
  logic [2:0]         r_tx_bv;

  logic               w_req0;
  logic               w_req1;
  logic               w_gnt;
  logic               w_start;
  logic               w_s0_ready;
  logic               w_s1_ready;
  logic [63:0]        w_data;
  logic               w_en;
  logic               w_sop;
  logic               w_eop;
  logic [2:0]         w_bv;
  logic               w_acc;
  logic               w_drop;
  logic               w_err;
  logic               w_done;

  assign w_req0 = bus.s0_en & bus.s0_sop;
  assign w_req1 = bus.s1_en & bus.s1_sop;
  // On a tie the source that did not win last time goes first.
  assign w_gnt  = (w_req0 & w_req1) ? ~r_rr : w_req1;

  assign w_data = r_grant ? bus.s1_data       : bus.s0_data;
  assign w_en   = r_grant ? bus.s1_en         : bus.s0_en;
  assign w_sop  = r_grant ? bus.s1_sop        : bus.s0_sop;
  assign w_eop  = r_grant ? bus.s1_eop        : bus.s0_eop;
  assign w_bv   = r_grant ? bus.s1_byte_vaild : bus.s0_byte_vaild;

  assign w_acc  = (r_state == ST_PKT) & w_en;
  // Missing sop on the first beat, or a stray sop on any later beat.
  assign w_err  = w_acc & (r_first ^ w_sop);
  assign w_drop = w_acc & r_first & ~w_sop;
  assign w_done = w_acc & w_eop;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_s0_ready  = 1'b0;
    w_s1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tx_ready && (w_req0 || w_req1)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        w_s0_ready = ~r_grant;
        w_s1_ready = r_grant;
        if (w_done) w_state_nxt = c_HAS_GAP ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge usclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= 1'b0;
      r_rr          <= 1'b0;
      r_first       <= 1'b0;
      r_gap_cnt     <= '0;
      r_tx_data     <= '0;
      r_tx_en       <= 1'b0;
      r_tx_sop      <= 1'b0;
      r_tx_eop      <= 1'b0;
      r_tx_bv       <= '0;
      s0_pkt_cnt    <= '0;
      s1_pkt_cnt    <= '0;
      proto_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start) begin
        r_grant <= w_gnt;
        r_rr    <= w_gnt;
        r_first <= 1'b1;
      end else if (w_acc) begin
        r_first <= 1'b0;
      end

      if (w_done && c_HAS_GAP) begin
        r_gap_cnt <= c_GAP_LOAD;
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end

      // tx_data holds its last value; the qualifiers drop whenever no beat is forwarded.
      if (w_acc && !w_drop) begin
        r_tx_data <= w_data;
        r_tx_en   <= 1'b1;
        r_tx_sop  <= w_sop & r_first;
        r_tx_eop  <= w_eop;
        r_tx_bv   <= w_eop ? w_bv : 3'd0;
      end else begin
        r_tx_en   <= 1'b0;
        r_tx_sop  <= 1'b0;
        r_tx_eop  <= 1'b0;
        r_tx_bv   <= 3'd0;
      end

      if (w_done && !r_grant) s0_pkt_cnt <= s0_pkt_cnt + CNT_W'(1);
      if (w_done &&  r_grant) s1_pkt_cnt <= s1_pkt_cnt + CNT_W'(1);
      if (w_err)              proto_err_cnt <= proto_err_cnt + CNT_W'(1);
    end
  end

  assign bus.s0_ready           = w_s0_ready;
  assign bus.s1_ready           = w_s1_ready;
  assign bus.tx_data            = r_tx_data;
  assign bus.tx_data_en         = r_tx_en;
  assign bus.tx_data_sop        = r_tx_sop;
  assign bus.tx_data_eop        = r_tx_eop;
  assign bus.tx_data_byte_vaild = r_tx_bv;
  assign busy                   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_xge_tx_arbiter.sv
// ==== tb_xge_tx_arbiter : directed self-checking bench for xge_tx_arbiter (rev 1.0) ====
`default_nettype none

module tb_xge_tx_arbiter;

  localparam int IPG_CYCLES = 1;
  localparam int CNT_W      = 32;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  bv;
  } beat_t;

  logic             usclk;
  logic             sys_rst;
  logic [CNT_W-1:0] s0_pkt_cnt;
  logic [CNT_W-1:0] s1_pkt_cnt;
  logic [CNT_W-1:0] proto_err_cnt;
  logic             busy;

  xge_tx_arbiter_if bus ();

  xge_tx_arbiter #(
    .IPG_CYCLES (IPG_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .usclk         (usclk),
    .sys_rst       (sys_rst),
    .bus           (bus),
    .s0_pkt_cnt    (s0_pkt_cnt),
    .s1_pkt_cnt    (s1_pkt_cnt),
    .proto_err_cnt (proto_err_cnt),
    .busy          (busy)
  );

  initial usclk = 1'b0;
  always #5 usclk = ~usclk;

  int    n_run;
  int    n_fail;
  int    cyc;
  beat_t q0[$];
  beat_t q1[$];
  int    sop_src[$];
  int    sop_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int src, input int pkt, input int idx,
                               input logic sop, input logic eop, input logic [2:0] bv);
    beat_t b;
    b.d   = {8'(src), 24'(pkt), 32'(idx)};
    b.sop = sop;
    b.eop = eop;
    b.bv  = bv;
    return b;
  endfunction

  task automatic present();
    bus.s0_en         = (q0.size() > 0);
    bus.s0_data       = (q0.size() > 0) ? q0[0].d   : 64'd0;
    bus.s0_sop        = (q0.size() > 0) ? q0[0].sop : 1'b0;
    bus.s0_eop        = (q0.size() > 0) ? q0[0].eop : 1'b0;
    bus.s0_byte_vaild = (q0.size() > 0) ? q0[0].bv  : 3'd0;
    bus.s1_en         = (q1.size() > 0);
    bus.s1_data       = (q1.size() > 0) ? q1[0].d   : 64'd0;
    bus.s1_sop        = (q1.size() > 0) ? q1[0].sop : 1'b0;
    bus.s1_eop        = (q1.size() > 0) ? q1[0].eop : 1'b0;
    bus.s1_byte_vaild = (q1.size() > 0) ? q1[0].bv  : 3'd0;
  endtask

  // One clock: retire handshaken beats, log output sops, present next heads.
  task automatic step();
    logic a0;
    logic a1;
    a0 = bus.s0_en & bus.s0_ready;
    a1 = bus.s1_en & bus.s1_ready;
    @(posedge usclk);
    #1;
    cyc++;
    if (a0 && q0.size() > 0) q0.delete(0);
    if (a1 && q1.size() > 0) q1.delete(0);
    if (bus.tx_data_en && bus.tx_data_sop) begin
      sop_src.push_back(int'(bus.tx_data[63:56]));
      sop_cyc.push_back(cyc);
    end
    present();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    q0.delete();
    q1.delete();
    present();
    @(posedge usclk);
    @(posedge usclk);
    #1;
    sys_rst = 1'b0;
    cyc = 0;
    sop_src.delete();
    sop_cyc.delete();
  endtask

  initial begin
    int alt_bad;
    int gap_bad;
    n_run  = 0;
    n_fail = 0;
    cyc    = 0;
    bus.tx_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_en",    bus.tx_data_en, 1'b0);
    chk("rst_data",  bus.tx_data, 64'd0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_cnt0",  s0_pkt_cnt, 0);
    chk("rst_err",   proto_err_cnt, 0);
    chk("rst_rdy0",  bus.s0_ready, 1'b0);

    // Single source, 3 beats, bv=5
    q0.push_back(mk(0, 1, 1, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(0, 1, 2, 1'b0, 1'b0, 3'd0));
    q0.push_back(mk(0, 1, 3, 1'b0, 1'b1, 3'd5));
    bus.tx_ready = 1'b1;
    present();
    step();
    chk("t1_grant_rdy", bus.s0_ready, 1'b1);
    chk("t1_grant_en",  bus.tx_data_en, 1'b0);
    chk("t1_busy",      busy, 1'b1);
    step();
    chk("t1_b1_data", bus.tx_data, mk(0, 1, 1, 1'b1, 1'b0, 3'd0).d);
    chk("t1_b1_ctl",  {bus.tx_data_en, bus.tx_data_sop, bus.tx_data_eop, bus.tx_data_byte_vaild}, {3'b110, 3'd0});
    step();
    chk("t1_b2_data", bus.tx_data, mk(0, 1, 2, 1'b0, 1'b0, 3'd0).d);
    chk("t1_b2_ctl",  {bus.tx_data_en, bus.tx_data_sop, bus.tx_data_eop, bus.tx_data_byte_vaild}, {3'b100, 3'd0});
    step();
    chk("t1_b3_data", bus.tx_data, mk(0, 1, 3, 1'b0, 1'b1, 3'd5).d);
    chk("t1_b3_ctl",  {bus.tx_data_en, bus.tx_data_sop, bus.tx_data_eop, bus.tx_data_byte_vaild}, {3'b101, 3'd5});
    chk("t1_cnt0",    s0_pkt_cnt, 1);
    chk("t1_err",     proto_err_cnt, 0);
    chk("t1_gap_rdy", bus.s0_ready, 1'b0);
    step();
    chk("t1_idle_en",   bus.tx_data_en, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_hold_data", bus.tx_data, mk(0, 1, 3, 1'b0, 1'b1, 3'd5).d);

    // Simultaneous requests from reset: s1 first, then s0
    do_reset();
    bus.tx_ready = 1'b1;
    q0.push_back(mk(0, 1, 1, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(0, 1, 2, 1'b0, 1'b1, 3'd0));
    q1.push_back(mk(1, 1, 1, 1'b1, 1'b0, 3'd0));
    q1.push_back(mk(1, 1, 2, 1'b0, 1'b1, 3'd0));
    present();
    for (int i = 0; i < 30 && (q0.size() > 0 || q1.size() > 0); i++) step();
    step();
    chk("t2_drained",  (q0.size() + q1.size()), 0);
    chk("t2_nsop",     sop_src.size(), 2);
    if (sop_src.size() == 2) begin
      chk("t2_first",   sop_src[0], 1);
      chk("t2_second",  sop_src[1], 0);
      chk("t2_spacing", sop_cyc[1] - sop_cyc[0], 2 + IPG_CYCLES + 1);
    end
    chk("t2_cnt0", s0_pkt_cnt, 1);
    chk("t2_cnt1", s1_pkt_cnt, 1);

    // Saturation: 10 two-beat packets per source
    do_reset();
    bus.tx_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      q0.push_back(mk(0, p, 1, 1'b1, 1'b0, 3'd0));
      q0.push_back(mk(0, p, 2, 1'b0, 1'b1, 3'd2));
      q1.push_back(mk(1, p, 1, 1'b1, 1'b0, 3'd0));
      q1.push_back(mk(1, p, 2, 1'b0, 1'b1, 3'd2));
    end
    present();
    for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0); i++) step();
    step();
    chk("t3_drained", (q0.size() + q1.size()), 0);
    chk("t3_nsop",    sop_src.size(), 20);
    alt_bad = 0;
    gap_bad = 0;
    for (int i = 0; i < sop_src.size(); i++) begin
      if (sop_src[i] != ((i % 2 == 0) ? 1 : 0)) alt_bad++;
      if (i > 0 && (sop_cyc[i] - sop_cyc[i-1]) != 2 + IPG_CYCLES + 1) gap_bad++;
    end
    chk("t3_alternate", alt_bad, 0);
    chk("t3_spacing",   gap_bad, 0);
    chk("t3_cnt0",      s0_pkt_cnt, 10);
    chk("t3_cnt1",      s1_pkt_cnt, 10);

    // tx_ready held low while s0 requests
    do_reset();
    bus.tx_ready = 1'b0;
    q0.push_back(mk(0, 7, 1, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(0, 7, 2, 1'b0, 1'b1, 3'd1));
    present();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_rdy", bus.s0_ready, 1'b0);
      chk("t4_hold_en",  bus.tx_data_en, 1'b0);
    end
    bus.tx_ready = 1'b1;
    step();
    chk("t4_grant_rdy", bus.s0_ready, 1'b1);
    chk("t4_grant_en",  bus.tx_data_en, 1'b0);
    step();
    chk("t4_first_ctl",  {bus.tx_data_en, bus.tx_data_sop}, 2'b11);
    chk("t4_first_data", bus.tx_data, mk(0, 7, 1, 1'b1, 1'b0, 3'd0).d);
    step();
    chk("t4_eop_ctl", {bus.tx_data_en, bus.tx_data_eop, bus.tx_data_byte_vaild}, {2'b11, 3'd1});
    step();

    // Protocol errors: first beat loses sop after grant, later beat carries a stray sop
    do_reset();
    bus.tx_ready = 1'b1;
    q0.push_back(mk(0, 9, 1, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(0, 9, 2, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(0, 9, 3, 1'b0, 1'b1, 3'd3));
    present();
    step();
    q0[0].sop = 1'b0;
    present();
    step();
    chk("t5_drop_en",  bus.tx_data_en, 1'b0);
    chk("t5_drop_err", proto_err_cnt, 1);
    step();
    chk("t5_mid_ctl",  {bus.tx_data_en, bus.tx_data_sop}, 2'b10);
    chk("t5_mid_data", bus.tx_data, mk(0, 9, 2, 1'b1, 1'b0, 3'd0).d);
    chk("t5_mid_err",  proto_err_cnt, 2);
    step();
    chk("t5_eop_ctl", {bus.tx_data_en, bus.tx_data_eop, bus.tx_data_byte_vaild}, {2'b11, 3'd3});
    chk("t5_cnt0",    s0_pkt_cnt, 1);
    chk("t5_err_end", proto_err_cnt, 2);
    step();

    // Asynchronous reset on beat 2 of 4
    for (int b = 1; b <= 4; b++) q0.push_back(mk(0, 11, b, b == 1, b == 4, 3'd0));
    present();
    step();
    step();
    step();
    chk("t6_b2_data", bus.tx_data, mk(0, 11, 2, 1'b0, 1'b0, 3'd0).d);
    chk("t6_b2_en",   bus.tx_data_en, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("t6_rst_en",   bus.tx_data_en, 1'b0);
    chk("t6_rst_data", bus.tx_data, 64'd0);
    chk("t6_rst_cnt0", s0_pkt_cnt, 0);
    chk("t6_rst_err",  proto_err_cnt, 0);
    chk("t6_rst_busy", busy, 1'b0);
    q0.delete();
    present();
    @(posedge usclk);
    #1;
    sys_rst = 1'b0;
    q0.push_back(mk(0, 12, 1, 1'b1, 1'b0, 3'd0));
    q0.push_back(mk(0, 12, 2, 1'b0, 1'b1, 3'd6));
    present();
    step();
    step();
    chk("t6_new_sop", {bus.tx_data_en, bus.tx_data_sop}, 2'b11);
    chk("t6_new_d1",  bus.tx_data, mk(0, 12, 1, 1'b1, 1'b0, 3'd0).d);
    step();
    chk("t6_new_eop", {bus.tx_data_en, bus.tx_data_eop, bus.tx_data_byte_vaild}, {2'b11, 3'd6});
    chk("t6_new_cnt", s0_pkt_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
